// File: rtl/video_frame_buffer_pkg.sv
// Shared encodings for the video frame buffer.
// Optional VGA output pipe: VFB_VGA_PIPE_EN.
package video_frame_buffer_pkg;

  localparam logic MODE_GFX  = 1'b0;
  localparam logic MODE_TEXT = 1'b1;

`ifdef VFB_VGA_PIPE_EN
  localparam int VGA_LAT = 2;
`else
  localparam int VGA_LAT = 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MERGE = 2'd1,
    ST_CLEAR = 2'd2
  } vfb_state_e;

endpackage

// File: rtl/video_frame_buffer_dpram.sv
// Read-first dual-port RAM, two lanes per word.
// Port A read/write with lane enables, port B read only.
module video_frame_buffer_dpram #(
  parameter int AW = 12,
  parameter int LW = 9
) (
  input  logic              clk_i,
  input  logic [1:0]        a_we_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [2*LW-1:0]   a_wdata_i,
  output logic [2*LW-1:0]   a_rdata_o,
  input  logic [AW-1:0]     b_addr_i,
  output logic [2*LW-1:0]   b_rdata_o
);

  logic [2*LW-1:0] mem_q [2**AW];

  // Port A: registered read of the old word, lane-masked write
  always_ff @(posedge clk_i) begin
    a_rdata_o <= mem_q[a_addr_i];
    if (a_we_i[0])
      mem_q[a_addr_i][LW-1:0] <= a_wdata_i[LW-1:0];
    if (a_we_i[1])
      mem_q[a_addr_i][2*LW-1:LW] <= a_wdata_i[2*LW-1:LW];
  end

  // Port B: registered read, sees pre-write data
  always_ff @(posedge clk_i) begin
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/video_frame_buffer.sv
// Video memory between CPU bus and VGA timing unit.
// Define VFB_VGA_PIPE_EN for an extra VGA output register.
module video_frame_buffer
  import video_frame_buffer_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int LANE_W = 9,
  parameter int PIX_W  = 3,
  parameter int SLOT_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SLOT_W+ADDR_W-1:0] cpu_addr,
  input  logic                     cpu_wr,
  input  logic                     cpu_rd,
  input  logic [7:0]               cpu_din,
  output logic [7:0]               cpu_dout,
  output logic                     cpu_rd_valid,
  output logic                     cpu_busy,
  input  logic                     clr_start,
  input  logic [7:0]               clr_data,
  output logic                     clr_done,
  input  logic [SLOT_W+ADDR_W-1:0] vga_addr,
  output logic [PIX_W-1:0]         vga_rgb_data,
  output logic [15:0]              vga_char_data
);

  localparam int PIX_PER_LANE = LANE_W / PIX_W;
  localparam int WA_W   = ADDR_W - 1;
  localparam int DEPTH  = 2**WA_W;
  localparam int CA_W   = SLOT_W + ADDR_W;
  localparam int WORD_W = 2 * LANE_W;
  localparam logic [WA_W-1:0] LAST = WA_W'(DEPTH - 1);

  function automatic logic [SLOT_W-1:0] eff_slot(
    input logic [SLOT_W-1:0] s
  );
    return (int'(s) >= PIX_PER_LANE) ? '0 : s;
  endfunction

  function automatic logic [PIX_W-1:0] get_pix(
    input logic [LANE_W-1:0] lane,
    input logic [SLOT_W-1:0] s
  );
    logic [LANE_W-1:0] sh;
    sh = lane >> (int'(eff_slot(s)) * PIX_W);
    return sh[PIX_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] put_pix(
    input logic [LANE_W-1:0] lane,
    input logic [SLOT_W-1:0] s,
    input logic [PIX_W-1:0]  p
  );
    logic [LANE_W-1:0] r;
    r = lane;
    for (int i = 0; i < PIX_PER_LANE; i++)
      if (int'(eff_slot(s)) == i)
        r[i*PIX_W +: PIX_W] = p;
    return r;
  endfunction

  function automatic logic [LANE_W-1:0] fill_lane(
    input logic       m,
    input logic [7:0] d
  );
    logic [LANE_W-1:0] r;
    r = '0;
    if (m == MODE_TEXT)
      r = LANE_W'(d);
    else
      for (int i = 0; i < PIX_PER_LANE; i++)
        r[i*PIX_W +: PIX_W] = d[PIX_W-1:0];
    return r;
  endfunction

  vfb_state_e state_q, state_d;

  logic [WA_W-1:0]   cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [WA_W-1:0]   word_q;
  logic              lane_q;
  logic [SLOT_W-1:0] slot_q;
  logic [PIX_W-1:0]  pix_q;
  logic              mode_q;
  logic [WORD_W-1:0] fill_q;

  logic [SLOT_W-1:0] cpu_slot;
  logic [WA_W-1:0]   cpu_word;
  logic              cpu_lane;
  logic [LANE_W-1:0] txt_lane;

  logic [1:0]        a_we;
  logic [WA_W-1:0]   a_addr;
  logic [WORD_W-1:0] a_wdata;
  logic [WORD_W-1:0] a_rdata;
  logic [LANE_W-1:0] a_lane;
  logic [LANE_W-1:0] m_lane;
  logic [WORD_W-1:0] b_rdata;

  assign cpu_lane = cpu_addr[0];
  assign cpu_word = cpu_addr[ADDR_W-1:1];
  assign cpu_slot = cpu_addr[CA_W-1:ADDR_W];
  assign txt_lane = LANE_W'(cpu_din);

  assign a_lane = lane_q ? a_rdata[WORD_W-1:LANE_W]
                         : a_rdata[LANE_W-1:0];
  assign m_lane = put_pix(a_lane, slot_q, pix_q);

  video_frame_buffer_dpram #(
    .AW (WA_W),
    .LW (LANE_W)
  ) u_ram (
    .clk_i     (clk),
    .a_we_i    (a_we),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (a_rdata),
    .b_addr_i  (vga_addr[ADDR_W-1:1]),
    .b_rdata_o (b_rdata)
  );

  // Control state, fill counter and request capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      word_q     <= '0;
      lane_q     <= 1'b0;
      slot_q     <= '0;
      pix_q      <= '0;
      mode_q     <= MODE_GFX;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      if (state_q == ST_IDLE) begin
        word_q <= cpu_word;
        lane_q <= cpu_lane;
        slot_q <= cpu_slot;
        pix_q  <= cpu_din[PIX_W-1:0];
        mode_q <= mode;
      end
      if (state_q == ST_IDLE && clr_start)
        fill_q <= {fill_lane(mode, clr_data),
                   fill_lane(mode, clr_data)};
    end
  end

  // Request arbitration, RAM port A control, fill sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    a_we       = 2'b00;
    a_addr     = cpu_word;
    a_wdata    = {txt_lane, txt_lane};
    unique case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (cpu_wr) begin
          if (mode == MODE_TEXT)
            a_we = cpu_lane ? 2'b10 : 2'b01;
          else
            state_d = ST_MERGE;
        end else if (cpu_rd) begin
          rd_valid_d = 1'b1;
        end
      end
      ST_MERGE: begin
        a_addr  = word_q;
        a_we    = lane_q ? 2'b10 : 2'b01;
        a_wdata = {m_lane, m_lane};
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        a_addr  = cnt_q;
        a_we    = 2'b11;
        a_wdata = fill_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n)
      a_we = 2'b00;
  end

  assign cpu_busy     = (state_q != ST_IDLE);
  assign cpu_rd_valid = rd_valid_q;
  assign clr_done     = done_q;

  // Read data formatting, only while the strobe is up
  always_comb begin
    cpu_dout = '0;
    if (rd_valid_q) begin
      if (mode_q == MODE_TEXT)
        cpu_dout = a_lane[7:0];
      else
        cpu_dout = 8'(get_pix(a_lane, slot_q));
    end
  end

  logic              v_vld_q;
  logic              v_lane_q;
  logic [SLOT_W-1:0] v_slot_q;
  logic [LANE_W-1:0] b_lane;
  logic [PIX_W-1:0]  rgb_c;
  logic [15:0]       char_c;

  // VGA address held alongside the port B read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_vld_q  <= 1'b0;
      v_lane_q <= 1'b0;
      v_slot_q <= '0;
    end else begin
      v_vld_q  <= 1'b1;
      v_lane_q <= vga_addr[0];
      v_slot_q <= vga_addr[CA_W-1:ADDR_W];
    end
  end

  assign b_lane = v_lane_q ? b_rdata[WORD_W-1:LANE_W]
                           : b_rdata[LANE_W-1:0];
  assign rgb_c  = v_vld_q ? get_pix(b_lane, v_slot_q) : '0;
  assign char_c = v_vld_q ? {b_rdata[LANE_W+7:LANE_W], b_rdata[7:0]}
                          : '0;

`ifdef VFB_VGA_PIPE_EN
  logic [PIX_W-1:0] rgb_q;
  logic [15:0]      char_q;

  // Extra VGA output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q  <= '0;
      char_q <= '0;
    end else begin
      rgb_q  <= rgb_c;
      char_q <= char_c;
    end
  end

  assign vga_rgb_data  = rgb_q;
  assign vga_char_data = char_q;
`else
  assign vga_rgb_data  = rgb_c;
  assign vga_char_data = char_c;
`endif

endmodule

// File: tb/tb_video_frame_buffer.sv
// Randomized self-checking bench for video_frame_buffer
// against a lane-array reference model.
module tb_video_frame_buffer;
  import video_frame_buffer_pkg::*;

  localparam int ADDR_W = 13;
  localparam int CA_W   = 15;
  localparam int NLANE  = 2**ADDR_W;
  localparam int PPL    = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mode = 1'b0;
  logic [CA_W-1:0] cpu_addr = '0;
  logic            cpu_wr = 1'b0;
  logic            cpu_rd = 1'b0;
  logic [7:0]      cpu_din = '0;
  logic [7:0]      cpu_dout;
  logic            cpu_rd_valid;
  logic            cpu_busy;
  logic            clr_start = 1'b0;
  logic [7:0]      clr_data = '0;
  logic            clr_done;
  logic [CA_W-1:0] vga_addr = '0;
  logic [2:0]      vga_rgb_data;
  logic [15:0]     vga_char_data;

  int n_run  = 0;
  int n_fail = 0;
  int mdl [NLANE];

  always #5 clk = ~clk;

  video_frame_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode          (mode),
    .cpu_addr      (cpu_addr),
    .cpu_wr        (cpu_wr),
    .cpu_rd        (cpu_rd),
    .cpu_din       (cpu_din),
    .cpu_dout      (cpu_dout),
    .cpu_rd_valid  (cpu_rd_valid),
    .cpu_busy      (cpu_busy),
    .clr_start     (clr_start),
    .clr_data      (clr_data),
    .clr_done      (clr_done),
    .vga_addr      (vga_addr),
    .vga_rgb_data  (vga_rgb_data),
    .vga_char_data (vga_char_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff(int s);
    return (s >= PPL) ? 0 : s;
  endfunction

  function automatic int pix_of(int lane, int s);
    return (lane / (8**eff(s))) % 8;
  endfunction

  function automatic int set_pix(int lane, int s, int c);
    int w;
    w = 8**eff(s);
    return lane - ((lane / w) % 8) * w + c * w;
  endfunction

  function automatic int char_of(int a);
    int w;
    w = (a % NLANE) / 2;
    return (mdl[2*w+1] % 256) * 256 + (mdl[2*w] % 256);
  endfunction

  task automatic gfx_write(int a, int c);
    mode = MODE_GFX;
    cpu_addr = CA_W'(a);
    cpu_din = 8'(c);
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    mode = 1'($urandom);
    check("gw_busy", cpu_busy, 1);
    tick();
    check("gw_idle", cpu_busy, 0);
    mdl[a % NLANE] = set_pix(mdl[a % NLANE], a / NLANE, c % 8);
  endtask

  task automatic text_write(int a, int d);
    mode = MODE_TEXT;
    cpu_addr = CA_W'(a);
    cpu_din = 8'(d);
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    check("tw_busy", cpu_busy, 0);
    mdl[a % NLANE] = d % 256;
  endtask

  task automatic cpu_read(int a, logic m);
    int exp;
    mode = m;
    cpu_addr = CA_W'(a);
    cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    mode = ~m;
    exp = m ? mdl[a % NLANE] % 256
            : pix_of(mdl[a % NLANE], a / NLANE);
    check("rd_valid", cpu_rd_valid, 1);
    check("rd_data", cpu_dout, exp);
    tick();
    check("rd_strobe", cpu_rd_valid, 0);
  endtask

  task automatic vga_check(int a);
    vga_addr = CA_W'(a);
    repeat (VGA_LAT) tick();
    check("vga_rgb", vga_rgb_data,
          pix_of(mdl[a % NLANE], a / NLANE));
    check("vga_char", vga_char_data, char_of(a));
  endtask

  task automatic run_clear(logic m, int d, logic hold_wr);
    int n, dn, rv, f;
    mode = m;
    clr_data = 8'(d);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    if (!hold_wr) cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    n = 0; dn = 0; rv = 0;
    while (cpu_busy && n < 5000) begin
      if (clr_done) dn++;
      if (cpu_rd_valid) rv++;
      tick();
      n++;
    end
    check("clr_cycles", n, 4096);
    check("clr_early_done", dn, 0);
    check("clr_no_rd", rv, 0);
    check("clr_done", clr_done, 1);
    f = m ? d % 256 : (d % 8) * 73;
    for (int i = 0; i < NLANE; i++) mdl[i] = f;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a, op, old;
    for (int i = 0; i < NLANE; i++) mdl[i] = 0;

    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", cpu_busy, 0);
    check("rst_rdv", cpu_rd_valid, 0);
    check("rst_dout", cpu_dout, 0);
    check("rst_done", clr_done, 0);
    check("rst_rgb", vga_rgb_data, 0);
    check("rst_char", vga_char_data, 0);
    rst_n = 1'b1;
    tick();

    run_clear(MODE_GFX, 0, 1'b0);
    tick();
    check("done_pulse", clr_done, 0);

    text_write('h0005, 'h41);
    cpu_read('h0005, MODE_TEXT);
    vga_check('h0004);
    check("t1_char_hi", vga_char_data[15:8], 'h41);

    gfx_write('h2010, 5);
    vga_check('h2010);
    check("t2_slot1", vga_rgb_data, 5);
    vga_check('h0010);
    check("t2_slot0", vga_rgb_data, 0);
    check("t2_lane", vga_char_data[7:0], 'h28);
    cpu_read('h2010, MODE_GFX);

    gfx_write('h6020, 6);
    vga_check('h0020);
    check("t3_slot0", vga_rgb_data, 6);
    vga_check('h2020);
    check("t3_slot1", vga_rgb_data, 0);
    vga_check('h4020);
    check("t3_slot2", vga_rgb_data, 0);
    cpu_read('h6020, MODE_GFX);

    for (int it = 0; it < 300; it++) begin
      a = int'($urandom_range(0, 3)) * NLANE
        + int'($urandom_range(0, 31));
      op = int'($urandom_range(0, 3));
      case (op)
        0: gfx_write(a, int'($urandom_range(0, 7)));
        1: text_write(a, int'($urandom_range(0, 255)));
        2: cpu_read(a, 1'($urandom));
        default: vga_check(a);
      endcase
    end

    old = mdl[100];
    vga_addr = CA_W'(100);
    mode = MODE_TEXT;
    cpu_addr = CA_W'(100);
    cpu_din = 8'h77;
    cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
    repeat (VGA_LAT - 1) tick();
    check("rf_old", vga_char_data[7:0], old % 256);
    tick();
    check("rf_new", vga_char_data[7:0], 'h77);
    mdl[100] = 'h77;

    cpu_wr = 1'b1;
    cpu_addr = CA_W'('h0033);
    cpu_din = 8'd2;
    run_clear(MODE_GFX, 3, 1'b1);
    tick();
    check("t4_wr_held", cpu_busy, 1);
    check("t4_done_once", clr_done, 0);
    cpu_wr = 1'b0;
    tick();
    check("t4_wr_done", cpu_busy, 0);
    mdl['h33] = set_pix(mdl['h33], 0, 2);
    for (int k = 0; k < 6; k++) begin
      a = int'($urandom_range(0, NLANE - 1));
      if (a == 'h33) a = 'h34;
      vga_check(a + 2 * NLANE);
      check("t4_333_px", vga_rgb_data, 3);
      check("t4_333_ch", vga_char_data, 'hdbdb);
    end
    vga_check('h0033);

    cpu_wr = 1'b1;
    cpu_rd = 1'b1;
    cpu_addr = CA_W'('h0007);
    cpu_din = 8'h11;
    run_clear(MODE_TEXT, 'h5a, 1'b0);
    check("t6_rdv", cpu_rd_valid, 0);
    tick();
    cpu_read('h0007, MODE_TEXT);
    vga_check('h0007);

    mode = MODE_GFX;
    clr_data = 8'd1;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    check("t5_busy", cpu_busy, 0);
    check("t5_rdv", cpu_rd_valid, 0);
    check("t5_dout", cpu_dout, 0);
    check("t5_done", clr_done, 0);
    check("t5_rgb", vga_rgb_data, 0);
    check("t5_char", vga_char_data, 0);
    rst_n = 1'b1;
    tick();
    check("t5_idle", cpu_busy, 0);
    for (int i = 0; i < 200; i++) mdl[i] = 'o111;
    vga_check(198);
    check("t5_w99", vga_char_data, 'h4949);
    vga_check(400);
    check("t5_w200", vga_char_data, 'h5a5a);
    vga_check(2 * NLANE + 1);
    check("t5_no_done", clr_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
